// File: rtl/biriscv_icache_arb.sv
// Two-requester arbiter for the biriscv L1 instruction cache port.
// Round-robin reads, in-order response routing, serialised flush/invalidate.
module biriscv_icache_arb #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int OUTSTANDING_W   = 1,
  parameter bit FIXED_PRIO      = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req0_rd_i,
  input  logic [31:0] req0_pc_i,
  input  logic [1:0]  req0_priv_i,
  input  logic        req0_flush_i,
  input  logic        req0_invalidate_i,
  output logic        req0_accept_o,
  output logic        req0_valid_o,
  output logic [63:0] req0_inst_o,
  output logic        req0_error_o,
  output logic        req0_page_fault_o,

  input  logic        req1_rd_i,
  input  logic [31:0] req1_pc_i,
  input  logic [1:0]  req1_priv_i,
  input  logic        req1_flush_i,
  input  logic        req1_invalidate_i,
  output logic        req1_accept_o,
  output logic        req1_valid_o,
  output logic [63:0] req1_inst_o,
  output logic        req1_error_o,
  output logic        req1_page_fault_o,

  output logic        icache_rd_o,
  output logic [31:0] icache_pc_o,
  output logic [1:0]  icache_priv_o,
  output logic        icache_flush_o,
  output logic        icache_invalidate_o,
  input  logic        icache_accept_i,
  input  logic        icache_valid_i,
  input  logic [63:0] icache_inst_i,
  input  logic        icache_error_i,
  input  logic        icache_page_fault_i,

  output logic        protocol_err_o
);

  localparam int CNT_W = OUTSTANDING_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0]           count_q;
  logic [CNT_W-1:0]           count_d;
  logic [OUTSTANDING_W-1:0]   wr_ptr_q;
  logic [OUTSTANDING_W-1:0]   rd_ptr_q;
  logic [MAX_OUTSTANDING-1:0] tag_q;

  logic lock_q;
  logic lock_id_q;
  logic rr_q;
  logic flush_pend_q;
  logic inv_pend_q;
  logic flush_q;
  logic inv_q;
  logic perr_q;

  logic grant;
  logic gnt_rd;
  logic full;
  logic fl_in;
  logic iv_in;
  logic block;
  logic push;
  logic pop;
  logic head;
  logic lock_d;
  logic idle;
  logic fl_src;
  logic iv_src;
  logic issue_fl;
  logic issue_iv;

  // rr_q=0 favours requester 0
  always_comb begin
    grant = 1'b0;
    if (lock_q)
      grant = lock_id_q;
    else if (FIXED_PRIO)
      grant = !req0_rd_i && req1_rd_i;
    else if (req0_rd_i && req1_rd_i)
      grant = rr_q;
    else
      grant = req1_rd_i;
  end

  assign gnt_rd = grant ? req1_rd_i : req0_rd_i;
  assign full   = (count_q == CNT_MAX);
  assign fl_in  = req0_flush_i | req1_flush_i;
  assign iv_in  = req0_invalidate_i | req1_invalidate_i;

  // Reads hold off until the last maintenance pulse has gone out
  assign block = flush_pend_q | inv_pend_q | flush_q
               | inv_q | fl_in | iv_in;

  assign icache_rd_o = rst_n && gnt_rd && !full
                    && (lock_q || !block);

  assign icache_pc_o   = !icache_rd_o ? '0 :
                         grant ? req1_pc_i : req0_pc_i;
  assign icache_priv_o = !icache_rd_o ? '0 :
                         grant ? req1_priv_i : req0_priv_i;

  assign push = icache_rd_o && icache_accept_i;
  assign pop  = icache_valid_i && (count_q != '0);
  assign head = tag_q[rd_ptr_q];

  assign req0_accept_o = push && !grant;
  assign req1_accept_o = push && grant;

  assign req0_valid_o = pop && !head;
  assign req1_valid_o = pop && head;

  assign req0_inst_o       = req0_valid_o ? icache_inst_i : '0;
  assign req1_inst_o       = req1_valid_o ? icache_inst_i : '0;
  assign req0_error_o      = req0_valid_o && icache_error_i;
  assign req1_error_o      = req1_valid_o && icache_error_i;
  assign req0_page_fault_o = req0_valid_o && icache_page_fault_i;
  assign req1_page_fault_o = req1_valid_o && icache_page_fault_i;

  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  assign lock_d  = icache_rd_o && !icache_accept_i;

  // Pulse fires once the cache will be quiet on the next cycle
  assign idle     = (count_d == '0) && !lock_d;
  assign fl_src   = flush_pend_q | fl_in;
  assign iv_src   = inv_pend_q | iv_in;
  assign issue_fl = idle && fl_src;
  assign issue_iv = idle && !fl_src && iv_src;

  assign icache_flush_o      = flush_q;
  assign icache_invalidate_o = inv_q;
  assign protocol_err_o      = perr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tag_q        <= '0;
      lock_q       <= 1'b0;
      lock_id_q    <= 1'b0;
      rr_q         <= 1'b0;
      flush_pend_q <= 1'b0;
      inv_pend_q   <= 1'b0;
      flush_q      <= 1'b0;
      inv_q        <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      count_q   <= count_d;
      lock_q    <= lock_d;
      lock_id_q <= grant;
      flush_q   <= issue_fl;
      inv_q     <= issue_iv;
      if (push) begin
        tag_q[wr_ptr_q] <= grant;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
        rr_q            <= !grant;
      end
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      if (icache_valid_i && count_q == '0)
        perr_q <= 1'b1;
      // An op that arrives while the pending one issues stays queued
      flush_pend_q <= issue_fl ? (flush_pend_q & fl_in) : fl_src;
      inv_pend_q   <= issue_iv ? (inv_pend_q & iv_in) : iv_src;
    end
  end

endmodule
